mult_issue_ctrl: RTL and testbench

//  Front/back-end controller for the NUM_STAGES-deep pipelined 64x64->low-64 multiplier chain.

---
 rtl/mult_pkg.sv | 27 ++
 rtl/mult_resp_fifo.sv | 77 +++++++
 rtl/mult_issue_ctrl.sv | 115 +++++++++++
 tb/tb_mult_issue_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// +--------------------------------------------------------------------+
// | mult_pkg : shared widths and response types for the multiplier    |
// | issue controller.                        Revision: 1.0            |
// +--------------------------------------------------------------------+
`default_nettype none

package mult_pkg;

  localparam int MULT_STAGES = 8;
  localparam int MULT_W      = 64;
  localparam int MULT_TAG_W  = 5;

  typedef logic [MULT_TAG_W-1:0] mult_tag_t;

  typedef struct packed {
    logic [MULT_W-1:0] product;
    mult_tag_t         tag;
  } mult_resp_t;

  // Counter width able to hold every value 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_resp_fifo.sv
// +--------------------------------------------------------------------+
// | mult_resp_fifo : synchronous response FIFO, head read from storage |
// | registers, no fall-through.              Revision: 1.0            |
// +--------------------------------------------------------------------+
`default_nettype none

module mult_resp_fifo
  import mult_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = mult_resp_t
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            push_i,
  input  ENTRY_T                          push_data_i,
  input  logic                            pop_i,
  output ENTRY_T                          head_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [credit_width(DEPTH)-1:0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = credit_width(DEPTH);

  ENTRY_T             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pop_ok;

  assign pop_ok  = pop_i & (count_q != '0);
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone qualifies the head.
  always_ff @(posedge clock_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  a_no_push_when_full: assert property (
    @(posedge clock_i) disable iff (reset_i) !(push_i && full_o)
  );

endmodule

`default_nettype wire

// File: rtl/mult_issue_ctrl.sv
// +--------------------------------------------------------------------+
// | mult_issue_ctrl : credit-based issue and response capture for the  |
// | pipelined 64x64 multiplier chain.        Revision: 1.0            |
// +--------------------------------------------------------------------+
`default_nettype none

module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int NUM_STAGES = MULT_STAGES,
  parameter int TAG_W      = MULT_TAG_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [MULT_W-1:0] req_mcand_i,
  input  logic [MULT_W-1:0] req_mplier_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  output logic              pipe_start_o,
  output logic [MULT_W-1:0] pipe_mcand_o,
  output logic [MULT_W-1:0] pipe_mplier_o,
  output logic [MULT_W-1:0] pipe_product_o,
  input  logic              pipe_done_i,
  input  logic [MULT_W-1:0] pipe_result_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [MULT_W-1:0] resp_product_o,
  output logic [TAG_W-1:0]  resp_tag_o
);

  localparam int CRED_W = credit_width(FIFO_DEPTH);

  typedef struct packed {
    logic [MULT_W-1:0] product;
    logic [TAG_W-1:0]  tag;
  } resp_t;

  logic [CRED_W-1:0] credit_q, credit_d;
  logic [TAG_W-1:0]  tag_line_q [NUM_STAGES];
  logic              issue;
  logic              deq;
  resp_t             push_entry;
  resp_t             head_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CRED_W-1:0] fifo_count;

  // Ready depends only on registered credits, never on resp_ready_i.
  assign req_ready_o    = (credit_q != '0) & ~reset_i;
  assign issue          = req_valid_i & req_ready_o;
  assign deq            = resp_valid_o & resp_ready_i;

  assign pipe_start_o   = issue;
  assign pipe_mcand_o   = req_mcand_i;
  assign pipe_mplier_o  = req_mplier_i;
  assign pipe_product_o = '0;

  always_comb begin
    credit_d = credit_q;
    if (issue && !deq) begin
      credit_d = credit_q - CRED_W'(1);
    end else if (deq && !issue) begin
      credit_d = credit_q + CRED_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      credit_q <= CRED_W'(FIFO_DEPTH);
    end else begin
      credit_q <= credit_d;
    end
  end

  // Tag line mirrors the non-stallable chain; pipe_done_i alone qualifies it.
  always_ff @(posedge clock_i) begin
    tag_line_q[0] <= req_tag_i;
    for (int i = 1; i < NUM_STAGES; i++) begin
      tag_line_q[i] <= tag_line_q[i-1];
    end
  end

  assign push_entry.product = pipe_result_i;
  assign push_entry.tag     = tag_line_q[NUM_STAGES-1];

  mult_resp_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .ENTRY_T (resp_t)
  ) u_resp_fifo (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .push_i      (pipe_done_i),
    .push_data_i (push_entry),
    .pop_i       (deq),
    .head_o      (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign resp_valid_o   = ~fifo_empty;
  assign resp_product_o = head_entry.product;
  assign resp_tag_o     = head_entry.tag;

  // Outstanding chain work = FIFO_DEPTH - credits - queued; a done needs at least one.
  a_done_has_issue: assert property (
    @(posedge clock_i) disable iff (reset_i)
      pipe_done_i |-> ((int'(credit_q) + int'(fifo_count)) < FIFO_DEPTH) && !fifo_full
  );

endmodule

`default_nettype wire

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl with a behavioural NUM_STAGES-deep multiplier chain.
`default_nettype none

module tb_mult_issue_ctrl;

  localparam int NS    = 8;
  localparam int TW    = 5;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [63:0]   req_mcand, req_mplier;
  logic [TW-1:0] req_tag;
  logic          pipe_start;
  logic [63:0]   pipe_mcand, pipe_mplier, pipe_product;
  logic          pipe_done;
  logic [63:0]   pipe_result;
  logic          resp_valid, resp_ready;
  logic [63:0]   resp_product;
  logic [TW-1:0] resp_tag;

  always #5 clock = ~clock;

  mult_issue_ctrl #(.NUM_STAGES(NS), .TAG_W(TW), .FIFO_DEPTH(DEPTH)) dut (
    .clock_i(clock), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_mcand_i(req_mcand), .req_mplier_i(req_mplier), .req_tag_i(req_tag),
    .pipe_start_o(pipe_start), .pipe_mcand_o(pipe_mcand),
    .pipe_mplier_o(pipe_mplier), .pipe_product_o(pipe_product),
    .pipe_done_i(pipe_done), .pipe_result_i(pipe_result),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_product_o(resp_product), .resp_tag_o(resp_tag)
  );

  // Multiplier chain model: full product formed at stage 0, carried through the rest.
  logic [NS-1:0] pd_q;
  logic [63:0]   pp_q [NS];
  always @(posedge clock) begin
    if (reset) pd_q <= '0;
    else       pd_q <= {pd_q[NS-2:0], pipe_start};
    pp_q[0] <= pipe_product + pipe_mcand * pipe_mplier;
    for (int i = 1; i < NS; i++) pp_q[i] <= pp_q[i-1];
  end
  assign pipe_done   = pd_q[NS-1];
  assign pipe_result = pp_q[NS-1];

  typedef struct packed { logic [63:0] p; logic [TW-1:0] t; } exp_t;
  exp_t exp_q [$];

  int total = 0;
  int bad   = 0;
  int nissue = 0;
  int nresp  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // One clock with scoreboard bookkeeping; inputs are already driven for this cycle.
  task automatic cyc();
    exp_t e;
    #1;
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_product", resp_product, e.p);
        chk("sb_tag", 64'(resp_tag), 64'(e.t));
        nresp++;
      end
    end
    if (req_valid && req_ready) begin
      e.p = req_mcand * req_mplier;
      e.t = req_tag;
      exp_q.push_back(e);
      nissue++;
    end
    tick();
  endtask

  task automatic single(input logic [63:0] a, input logic [63:0] b,
                        input logic [TW-1:0] t, input logic [63:0] expp);
    int lat;
    req_valid = 1'b1; req_mcand = a; req_mplier = b; req_tag = t; resp_ready = 1'b1;
    #1;
    chk("single_ready", 64'(req_ready), 64'd1);
    chk("single_start", 64'(pipe_start), 64'd1);
    chk("single_pipe_prod_in", pipe_product, 64'd0);
    tick();
    req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      #1;
      if (resp_valid) begin lat = k; break; end
      tick();
    end
    chk("single_latency", 64'(lat), 64'(NS + 1));
    chk("single_product", resp_product, expp);
    chk("single_tag", 64'(resp_tag), 64'(t));
    tick();
    chk("single_drained", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    int n0, seen;
    logic need_new;
    reset = 1'b1; req_valid = 1'b0; req_mcand = '0; req_mplier = '0; req_tag = '0;
    resp_ready = 1'b0;
    tick(); tick();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    chk("post_rst_credits", 64'(dut.credit_q), 64'(DEPTH));
    tick();

    // Single transactions, including wrap-around products.
    single(64'd3, 64'd5, 5'd1, 64'd15);
    single(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    single(64'h1_0000_0000, 64'h1_0000_0000, 5'd3, 64'd0);

    // Streamed random requests, consumer always ready.
    resp_ready = 1'b1; nissue = 0; nresp = 0; need_new = 1'b1;
    req_valid = 1'b1;
    for (int c = 0; c < 400 && nissue < 20; c++) begin
      if (need_new) begin
        req_mcand  = {$urandom, $urandom};
        req_mplier = {$urandom, $urandom};
        req_tag    = TW'(nissue);
        need_new   = 1'b0;
      end
      n0 = nissue;
      cyc();
      if (nissue != n0) need_new = 1'b1;
    end
    req_valid = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) cyc();
    chk("stream_issued", 64'(nissue), 64'd20);
    chk("stream_resps", 64'(nresp), 64'd20);

    // Stalled consumer: exactly DEPTH issues, then ready drops.
    resp_ready = 1'b0; nissue = 0; nresp = 0; req_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      req_mcand = 64'(c + 7); req_mplier = 64'(c + 100); req_tag = TW'(c);
      cyc();
    end
    chk("stall_issues", 64'(nissue), 64'(DEPTH));
    chk("stall_ready_low", 64'(req_ready), 64'd0);
    chk("stall_credits", 64'(dut.credit_q), 64'd0);
    resp_ready = 1'b1;
    #1;
    chk("cred0_deq_valid", 64'(resp_valid), 64'd1);
    chk("cred0_deq_no_ready", 64'(req_ready), 64'd0);
    cyc();
    req_valid = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) cyc();
    chk("stall_drain_empty", 64'(exp_q.size()), 64'd0);
    chk("stall_drain_resps", 64'(nresp), 64'(nissue));

    // Same-cycle issue and dequeue at credits==1.
    resp_ready = 1'b0; req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req_mcand = 64'(c + 2); req_mplier = 64'd9; req_tag = TW'(c + 10);
      cyc();
    end
    req_valid = 1'b0;
    for (int c = 0; c < 12; c++) cyc();
    chk("c1_credits_before", 64'(dut.credit_q), 64'd1);
    chk("c1_resp_valid", 64'(resp_valid), 64'd1);
    req_valid = 1'b1; resp_ready = 1'b1; req_mcand = 64'd11; req_mplier = 64'd13; req_tag = 5'd20;
    cyc();
    req_valid = 1'b0; resp_ready = 1'b0;
    #1;
    chk("c1_credits_after", 64'(dut.credit_q), 64'd1);
    chk("c1_ready_after", 64'(req_ready), 64'd1);
    tick();
    resp_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) cyc();
    chk("c1_drain_empty", 64'(exp_q.size()), 64'd0);

    // Reset with two queued and two in flight.
    resp_ready = 1'b0; req_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      req_mcand = 64'(c + 3); req_mplier = 64'd4; req_tag = TW'(c);
      cyc();
    end
    req_valid = 1'b0;
    for (int c = 0; c < 10; c++) cyc();
    req_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      req_mcand = 64'(c + 5); req_mplier = 64'd6; req_tag = TW'(c + 2);
      cyc();
    end
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) cyc();
    chk("prerst_valid", 64'(resp_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'd0);
    tick();
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("rst2_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst2_credits", 64'(dut.credit_q), 64'(DEPTH));
    chk("rst2_ready", 64'(req_ready), 64'd1);
    resp_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (resp_valid) seen++;
      tick();
    end
    chk("rst2_no_stray_resp", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
